// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, sequencer states and result encoding.
// The opcode values are also used by the 7-segment decode path.
package alu_pkg;

  localparam int RES_W = 8;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MULT = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;

  localparam logic [RES_W-1:0] DIV0_VAL = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DIV,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic             err;
    logic [RES_W-1:0] res;
  } alu_res_t;

endpackage

// File: rtl/alu_div_iter.sv
// 4-bit iterative restoring divider, one quotient bit per cycle, MSB first.
// The dividend register shifts left and collects quotient bits in its LSB.
module alu_div_iter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [3:0] dividend_i,
  input  logic [3:0] divisor_i,
  output logic [3:0] quotient_o,
  output logic       done_o
);

  logic [3:0] rem_q;
  logic [3:0] qd_q;
  logic [3:0] dvs_q;
  logic [1:0] cnt_q;
  logic       run_q;

  logic [4:0] rem_shift;
  logic [4:0] diff;
  logic       fits;

  // The partial remainder stays below the divisor, so bit 4 of diff is a clean borrow.
  assign rem_shift  = {rem_q, qd_q[3]};
  assign diff       = rem_shift - {1'b0, dvs_q};
  assign fits       = ~diff[4];
  assign quotient_o = {qd_q[2:0], fits};
  assign done_o     = run_q & (cnt_q == 2'd3);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q <= '0;
      qd_q  <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      rem_q <= '0;
      qd_q  <= dividend_i;
      dvs_q <= divisor_i;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      rem_q <= fits ? diff[3:0] : rem_shift[3:0];
      qd_q  <= quotient_o;
      cnt_q <= cnt_q + 2'd1;
      if (cnt_q == 2'd3) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer sharing one 4-bit ALU between requesters;
// returns an 8-bit result tagged with the owning requester ID.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [4*NUM_REQ-1:0] op_i,
  input  logic [4*NUM_REQ-1:0] a_i,
  input  logic [4*NUM_REQ-1:0] b_i,
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [RES_W-1:0]     result_o,
  output logic [ID_W-1:0]      res_id_o,
  output logic                 err_o
);

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic [3:0]             op_q, op_d, a_q, a_d, b_q, b_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [RES_W-1:0]       result_q, result_d;
  logic [ID_W-1:0]        res_id_q, res_id_d;
  logic                   err_q, err_d;

  logic [3:0]             op_arr [NUM_REQ];
  logic [3:0]             a_arr  [NUM_REQ];
  logic [3:0]             b_arr  [NUM_REQ];
  logic                   found;
  logic [ID_W-1:0]        winner, cand;
  logic                   div_start, div_done;
  logic [3:0]             div_quot;
  alu_res_t               alu_out;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_arr[g] = op_i[4*g +: 4];
    assign a_arr[g]  = a_i[4*g +: 4];
    assign b_arr[g]  = b_i[4*g +: 4];
  end

  // DIV is only evaluated here when B=0; a nonzero divisor goes to the iterative divider.
  function automatic alu_res_t alu_eval(input logic [3:0] op, input logic [3:0] a,
                                        input logic [3:0] b);
    alu_res_t r;
    r.err = 1'b0;
    r.res = '0;
    case (op)
      OP_ADD:  r.res = {4'b0, a} + {4'b0, b};
      OP_SUB:  r.res = (a < b) ? '0 : {4'b0, a - b};
      OP_MULT: r.res = {4'b0, a} * {4'b0, b};
      OP_DIV:  begin r.res = DIV0_VAL; r.err = 1'b1; end
      OP_AND:  r.res = {4'b0, a & b};
      OP_OR:   r.res = {4'b0, a | b};
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  assign alu_out = alu_eval(op_q, a_q, b_q);

  // Search starts one past the last grant and wraps, so the last winner has lowest priority.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    cand   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = ID_W'((int'(ptr_q) + off) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // NOTE: every signal driven here gets a default first so no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    gnt_d     = '0;
    result_d  = result_q;
    res_id_d  = res_id_q;
    err_d     = err_q;
    div_start = 1'b0;
    case (state_q)
      ST_IDLE: if (found) begin
        ptr_d         = winner;
        id_d          = winner;
        op_d          = op_arr[winner];
        a_d           = a_arr[winner];
        b_d           = b_arr[winner];
        gnt_d[winner] = 1'b1;
        state_d       = ST_EXEC;
      end
      ST_EXEC: if (op_q == OP_DIV && b_q != 4'd0) begin
        div_start = 1'b1;
        state_d   = ST_DIV;
      end else begin
        result_d = alu_out.res;
        err_d    = alu_out.err;
        res_id_d = id_q;
        state_d  = ST_DONE;
      end
      ST_DIV: if (div_done) begin
        result_d = {4'b0, div_quot};
        err_d    = 1'b0;
        res_id_d = id_q;
        state_d  = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      ptr_q    <= ID_W'(NUM_REQ - 1);
      id_q     <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      gnt_q    <= '0;
      result_q <= '0;
      res_id_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      gnt_q    <= gnt_d;
      result_q <= result_d;
      res_id_q <= res_id_d;
      err_q    <= err_d;
    end
  end

  alu_div_iter u_div (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (div_start),
    .dividend_i (a_q),
    .divisor_i  (b_q),
    .quotient_o (div_quot),
    .done_o     (div_done)
  );

  assign gnt_o    = gnt_q;
  assign busy_o   = (state_q != ST_IDLE);
  assign done_o   = (state_q == ST_DONE);
  assign result_o = result_q;
  assign res_id_o = res_id_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with four requesters.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NUM_REQ = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] op, a, b;
  logic [3:0]  gnt;
  logic        busy, done, err;
  logic [7:0]  result;
  logic [1:0]  res_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .gnt_o    (gnt),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result),
    .res_id_o (res_id),
    .err_o    (err)
  );

  function automatic int oh_id(input logic [3:0] g);
    case (g)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic set_req(input int id, input logic [3:0] o, input logic [3:0] x,
                         input logic [3:0] y);
    op[4*id +: 4] = o;
    a[4*id +: 4]  = x;
    b[4*id +: 4]  = y;
    req[id]       = 1'b1;
  endtask

  task automatic wait_gnt(output int n, output logic [3:0] g);
    n = -1;
    g = '0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (gnt != 4'b0) begin
        n = i;
        g = gnt;
        break;
      end
    end
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // lat counts edges from the grant edge to the edge that first samples DONE high.
  task automatic run_op(input int id, input logic [3:0] o, input logic [3:0] x,
                        input logic [3:0] y, output logic [3:0] g, output logic [3:0] g_after,
                        output int lat, output logic [7:0] r, output logic [1:0] rid,
                        output logic e);
    int n;
    set_req(id, o, x, y);
    wait_gnt(n, g);
    req[id] = 1'b0;
    lat     = -1;
    g_after = '1;
    if (n >= 0) begin
      @(negedge clk);
      g_after = gnt;
      if (done) lat = 2;
      else begin
        wait_done(n);
        lat = (n < 0) ? -1 : n + 2;
      end
    end
    r   = result;
    rid = res_id;
    e   = err;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    op  = '0;
    a   = '0;
    b   = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (gnt !== 4'b0) begin
      errors++;
      $display("FAIL reset_gnt: got %b expected 0000", gnt);
    end
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_busy_done: got %b expected 00", {busy, done});
    end
    checks++;
    if ({result, res_id, err} !== 11'd0) begin
      errors++;
      $display("FAIL reset_result: got res=%h id=%0d err=%b expected all 0", result, res_id, err);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_add();
    logic [3:0] g, ga;
    int         lat;
    logic [7:0] r;
    logic [1:0] rid;
    logic       e;
    run_op(0, OP_ADD, 4'd7, 4'd9, g, ga, lat, r, rid, e);
    checks++;
    if (g !== 4'b0001) begin errors++; $display("FAIL add_gnt: got %b expected 0001", g); end
    checks++;
    if (ga !== 4'b0000) begin errors++; $display("FAIL add_gnt_pulse: got %b expected 0000", ga); end
    checks++;
    if (lat != 2) begin errors++; $display("FAIL add_latency: got %0d expected 2", lat); end
    checks++;
    if ({r, rid, e} !== {8'h10, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL add_result: got res=%h id=%0d err=%b expected 10/0/0", r, rid, e);
    end
  endtask

  task automatic test_fairness();
    int exp_ids [8] = '{0, 1, 2, 3, 0, 2, 0, 2};
    int got  = 0;
    int last = 0;
    int id, n;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, OP_ADD, 4'(i), 4'd1);
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk);
      if (gnt != 4'b0) begin
        id = oh_id(gnt);
        checks++;
        if (id != exp_ids[got]) begin
          errors++;
          $display("FAIL fair_order[%0d]: got %0d expected %0d", got, id, exp_ids[got]);
        end
        if (got > 0) begin
          checks++;
          if (c - last != 3) begin
            errors++;
            $display("FAIL fair_spacing[%0d]: got %0d expected 3", got, c - last);
          end
        end
        last = c;
        got++;
        if (got == 5) req = 4'b0101;
        if (got == 8) req = 4'b0000;
      end
    end
    checks++;
    if (got != 8) begin errors++; $display("FAIL fair_count: got %0d expected 8", got); end
    wait_done(n);
    checks++;
    if (n < 0) begin errors++; $display("FAIL fair_drain: got timeout expected DONE"); end
  endtask

  task automatic test_div();
    logic [3:0] g, ga;
    int         lat;
    logic [7:0] r;
    logic [1:0] rid;
    logic       e;
    run_op(1, OP_DIV, 4'd15, 4'd4, g, ga, lat, r, rid, e);
    checks++;
    if (g !== 4'b0010) begin errors++; $display("FAIL div_gnt: got %b expected 0010", g); end
    checks++;
    if (lat != 6) begin errors++; $display("FAIL div_latency: got %0d expected 6", lat); end
    checks++;
    if ({r, rid, e} !== {8'h03, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL div_15_4: got res=%h id=%0d err=%b expected 03/1/0", r, rid, e);
    end
    run_op(2, OP_DIV, 4'd5, 4'd0, g, ga, lat, r, rid, e);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL div0_latency: got %0d expected 2", lat); end
    checks++;
    if ({r, rid, e} !== {8'hFF, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL div0_result: got res=%h id=%0d err=%b expected FF/2/1", r, rid, e);
    end
    run_op(3, OP_DIV, 4'd14, 4'd3, g, ga, lat, r, rid, e);
    checks++;
    if ({r, rid, e, lat} !== {8'h04, 2'd3, 1'b0, 32'd6}) begin
      errors++;
      $display("FAIL div_14_3: got res=%h id=%0d err=%b lat=%0d expected 04/3/0/6", r, rid, e, lat);
    end
  endtask

  task automatic test_arith_edges();
    logic [3:0] v_op  [7] = '{OP_SUB, OP_SUB, OP_MULT, OP_ADD, 4'd9, OP_AND, OP_OR};
    logic [3:0] v_a   [7] = '{4'd3, 4'd9, 4'd15, 4'd15, 4'd1, 4'hC, 4'hC};
    logic [3:0] v_b   [7] = '{4'd9, 4'd3, 4'd15, 4'd15, 4'd1, 4'hA, 4'hA};
    logic [7:0] v_res [7] = '{8'h00, 8'h06, 8'hE1, 8'h1E, 8'h00, 8'h08, 8'h0E};
    logic       v_err [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] g, ga;
    int         lat;
    logic [7:0] r;
    logic [1:0] rid;
    logic       e;
    for (int i = 0; i < 7; i++) begin
      run_op(i % 4, v_op[i], v_a[i], v_b[i], g, ga, lat, r, rid, e);
      checks++;
      if ({r, e, rid} !== {v_res[i], v_err[i], 2'(i % 4)} || lat != 2) begin
        errors++;
        $display("FAIL arith[%0d]: got res=%h err=%b id=%0d lat=%0d expected %h/%b/%0d/2",
                 i, r, e, rid, lat, v_res[i], v_err[i], i % 4);
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({done, result, res_id} !== {1'b0, 8'h0E, 2'd2}) begin
        errors++;
        $display("FAIL result_hold[%0d]: got done=%b res=%h id=%0d expected 0/0E/2",
                 i, done, result, res_id);
      end
    end
  endtask

  task automatic test_reset_mid_div();
    logic [3:0] g;
    int         n;
    logic       saw_done = 1'b0;
    set_req(0, OP_DIV, 4'd15, 4'd4);
    wait_gnt(n, g);
    req = '0;
    checks++;
    if (g !== 4'b0001) begin errors++; $display("FAIL rdiv_gnt: got %b expected 0001", g); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt, busy, done, result, res_id, err} !== 17'd0) begin
      errors++;
      $display("FAIL rdiv_outputs: got gnt=%b busy=%b done=%b res=%h id=%0d err=%b expected all 0",
               gnt, busy, done, result, res_id, err);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL rdiv_no_done: got DONE expected none"); end
    set_req(3, OP_ADD, 4'd1, 4'd1);
    set_req(0, OP_ADD, 4'd1, 4'd2);
    wait_gnt(n, g);
    req = '0;
    checks++;
    if (g !== 4'b0001) begin errors++; $display("FAIL rdiv_first_gnt: got %b expected 0001", g); end
    wait_done(n);
    checks++;
    if ({result, res_id} !== {8'h03, 2'd0} || n < 0) begin
      errors++;
      $display("FAIL rdiv_after: got res=%h id=%0d wait=%0d expected 03/0", result, res_id, n);
    end
  endtask

  task automatic test_late_request();
    logic [3:0] g;
    logic [3:0] g2    = '0;
    int         n;
    int         gc    = -1;
    int         id0   = -1;
    logic [7:0] res0  = '0;
    set_req(0, OP_MULT, 4'd3, 4'd5);
    wait_gnt(n, g);
    req[0] = 1'b0;
    checks++;
    if (g !== 4'b0001) begin errors++; $display("FAIL late_gnt0: got %b expected 0001", g); end
    set_req(1, OP_ADD, 4'd2, 4'd2);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done && id0 < 0) begin
        id0  = int'(res_id);
        res0 = result;
      end
      if (gnt != 4'b0) begin
        g2 = gnt;
        gc = c;
        break;
      end
    end
    req[1] = 1'b0;
    checks++;
    if (g2 !== 4'b0010 || gc != 3) begin
      errors++;
      $display("FAIL late_gnt1: got %b after %0d cycles expected 0010 after 3", g2, gc);
    end
    checks++;
    if (id0 != 0 || res0 !== 8'h0F) begin
      errors++;
      $display("FAIL late_first_result: got id=%0d res=%h expected 0/0F", id0, res0);
    end
    wait_done(n);
    checks++;
    if ({result, res_id} !== {8'h04, 2'd1} || n < 0) begin
      errors++;
      $display("FAIL late_second_result: got res=%h id=%0d wait=%0d expected 04/1", result, res_id, n);
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_fairness();
    test_div();
    test_arith_edges();
    test_reset_mid_div();
    test_late_request();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
